// File: rtl/boss_ctl.sv
`default_nettype none
// ============================================================================
// boss_ctl : frame-stepped boss behaviour (spawn/patrol/jump/dead), HP and
//            invulnerability. Option macro: BOSS_ENRAGE_EN (faster at half HP).
// Rev 1.0
// ============================================================================
module boss_ctl #(
    parameter int X_MIN         = 106,
    parameter int X_MAX         = 694,
    parameter int SPAWN_X       = 400,
    parameter int SPAWN_Y       = 95,
    parameter int GROUND_Y      = 505,
    parameter int MAX_HP        = 100,
    parameter int SPEED         = 2,
    parameter int JUMP_V0       = 12,
    parameter int GRAVITY       = 1,
    parameter int PATROL_FRAMES = 120,
    parameter int INVULN_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  game_active,
    input  logic        frame_tick,
    input  logic        hit,
    input  logic [6:0]  hit_dmg,
    output logic [11:0] boss_x,
    output logic [11:0] boss_y,
    output logic [6:0]  boss_hp,
    output logic        boss_defeated,
    output logic        boss_invuln
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SPAWN  = 3'd1,
        S_PATROL = 3'd2,
        S_JUMP   = 3'd3,
        S_DEAD   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic signed [7:0] vy_q, vy_d;
    logic [6:0]        patrol_cnt_q, patrol_cnt_d;
    logic [4:0]        inv_cnt_q, inv_cnt_d;
    logic [11:0]       x_q, x_d, y_q, y_d;
    logic [6:0]        hp_q, hp_d;
    logic              defeated_q, defeated_d;
    logic              invuln_q, invuln_d;

    logic [12:0] step;
    logic [6:0]  patrol_last;
`ifdef BOSS_ENRAGE_EN
    logic enraged;
    assign enraged     = (hp_q <= 7'(MAX_HP / 2));
    assign step        = enraged ? 13'(2 * SPEED) : 13'(SPEED);
    assign patrol_last = enraged ? 7'(PATROL_FRAMES / 2 - 1) : 7'(PATROL_FRAMES - 1);
`else
    assign step        = 13'(SPEED);
    assign patrol_last = 7'(PATROL_FRAMES - 1);
`endif

    // Horizontal patrol step with edge clamp and direction flip (shared by PATROL/JUMP)
    logic [12:0] x_right, x_left;
    logic [11:0] hx;
    logic        hdir;
    assign x_right = {1'b0, x_q} + step;
    assign x_left  = {1'b0, x_q} - step;

    always_comb begin
        hx   = x_q;
        hdir = dir_q;
        if (!dir_q) begin
            if (x_right >= 13'(X_MAX)) begin
                hx   = 12'(X_MAX);
                hdir = 1'b1;
            end else begin
                hx = x_right[11:0];
            end
        end else begin
            if (x_left[12] || x_left <= 13'(X_MIN)) begin
                hx   = 12'(X_MIN);
                hdir = 1'b0;
            end else begin
                hx = x_left[11:0];
            end
        end
    end

    logic [12:0]        y_spawn;
    logic signed [13:0] y_jump;
    logic               hit_ok;
    logic [6:0]         hp_sub;
    assign y_spawn = {1'b0, y_q} + 13'(SPEED);
    assign y_jump  = $signed({2'b00, y_q}) + {{6{vy_q[7]}}, vy_q};
    assign hit_ok  = hit && (inv_cnt_q == 5'd0) &&
                     (state_q == S_PATROL || state_q == S_JUMP);
    assign hp_sub  = (hit_dmg >= hp_q) ? 7'd0 : (hp_q - hit_dmg);

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        vy_d         = vy_q;
        patrol_cnt_d = patrol_cnt_q;
        inv_cnt_d    = inv_cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        hp_d         = hp_q;
        defeated_d   = 1'b0;
        case (game_active)
            2'd0: begin
                state_d      = S_IDLE;
                dir_d        = 1'b0;
                vy_d         = 8'sd0;
                patrol_cnt_d = 7'd0;
                inv_cnt_d    = 5'd0;
                x_d          = 12'(SPAWN_X);
                y_d          = 12'(SPAWN_Y);
                hp_d         = 7'(MAX_HP);
            end
            2'd1: begin
                if (frame_tick) begin
                    if (state_q != S_IDLE && inv_cnt_q != 5'd0)
                        inv_cnt_d = inv_cnt_q - 5'd1;
                    case (state_q)
                        S_IDLE: state_d = S_SPAWN;
                        S_SPAWN: begin
                            if (y_spawn >= 13'(GROUND_Y)) begin
                                y_d          = 12'(GROUND_Y);
                                state_d      = S_PATROL;
                                patrol_cnt_d = 7'd0;
                            end else begin
                                y_d = y_spawn[11:0];
                            end
                        end
                        S_PATROL: begin
                            x_d   = hx;
                            dir_d = hdir;
                            if (patrol_cnt_q >= patrol_last) begin
                                state_d      = S_JUMP;
                                vy_d         = 8'sd0 - 8'(JUMP_V0);
                                patrol_cnt_d = 7'd0;
                            end else begin
                                patrol_cnt_d = patrol_cnt_q + 7'd1;
                            end
                        end
                        S_JUMP: begin
                            x_d   = hx;
                            dir_d = hdir;
                            if (y_jump >= $signed(14'(GROUND_Y))) begin
                                y_d          = 12'(GROUND_Y);
                                vy_d         = 8'sd0;
                                state_d      = S_PATROL;
                                patrol_cnt_d = 7'd0;
                            end else begin
                                y_d  = y_jump[11:0];
                                vy_d = vy_q + 8'(GRAVITY);
                            end
                        end
                        default: ;
                    endcase
                end
                // A killing hit overrides any same-cycle state change but keeps the motion
                if (hit_ok) begin
                    hp_d      = hp_sub;
                    inv_cnt_d = 5'(INVULN_FRAMES);
                    if (hp_sub == 7'd0) begin
                        state_d    = S_DEAD;
                        defeated_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        invuln_d = (inv_cnt_d != 5'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dir_q        <= 1'b0;
            vy_q         <= 8'sd0;
            patrol_cnt_q <= 7'd0;
            inv_cnt_q    <= 5'd0;
            x_q          <= 12'(SPAWN_X);
            y_q          <= 12'(SPAWN_Y);
            hp_q         <= 7'(MAX_HP);
            defeated_q   <= 1'b0;
            invuln_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            vy_q         <= vy_d;
            patrol_cnt_q <= patrol_cnt_d;
            inv_cnt_q    <= inv_cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hp_q         <= hp_d;
            defeated_q   <= defeated_d;
            invuln_q     <= invuln_d;
        end
    end

    assign boss_x        = x_q;
    assign boss_y        = y_q;
    assign boss_hp       = hp_q;
    assign boss_defeated = defeated_q;
    assign boss_invuln   = invuln_q;

endmodule
`default_nettype wire

// File: tb/tb_boss_ctl.sv
`default_nettype none
// ============================================================================
// tb_boss_ctl : directed testbench for boss_ctl (default build).
// Rev 1.0
// ============================================================================
module tb_boss_ctl;

    logic        clk;
    logic        rst;
    logic [1:0]  game_active;
    logic        frame_tick;
    logic        hit;
    logic [6:0]  hit_dmg;
    logic [11:0] boss_x;
    logic [11:0] boss_y;
    logic [6:0]  boss_hp;
    logic        boss_defeated;
    logic        boss_invuln;

    int checks_q;
    int failures_q;

    boss_ctl u_dut (
        .clk           (clk),
        .rst           (rst),
        .game_active   (game_active),
        .frame_tick    (frame_tick),
        .hit           (hit),
        .hit_dmg       (hit_dmg),
        .boss_x        (boss_x),
        .boss_y        (boss_y),
        .boss_hp       (boss_hp),
        .boss_defeated (boss_defeated),
        .boss_invuln   (boss_invuln)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks_q++;
        if (got != exp) begin
            failures_q++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic do_hit(input logic [6:0] dmg, input logic with_tick);
        @(negedge clk);
        hit        = 1'b1;
        hit_dmg    = dmg;
        frame_tick = with_tick;
        @(negedge clk);
        hit        = 1'b0;
        hit_dmg    = 7'd0;
        frame_tick = 1'b0;
    endtask

    initial begin
        checks_q    = 0;
        failures_q  = 0;
        rst         = 1'b1;
        game_active = 2'd0;
        frame_tick  = 1'b0;
        hit         = 1'b0;
        hit_dmg     = 7'd0;
        repeat (3) @(negedge clk);
        check("rst_x", boss_x, 400);
        check("rst_y", boss_y, 95);
        check("rst_hp", boss_hp, 100);
        check("rst_def", boss_defeated, 0);
        check("rst_inv", boss_invuln, 0);
        rst = 1'b0;
        game_active = 2'd1;

        // Spawn descent: first tick only leaves IDLE, then 205 ticks of +2
        tick(1);
        check("idle_to_spawn_y", boss_y, 95);
        tick(204);
        check("spawn_y_204", boss_y, 503);
        tick(1);
        check("spawn_land_y", boss_y, 505);
        check("spawn_x", boss_x, 400);

        // Patrol and invulnerability window
        tick(1);
        check("patrol_x1", boss_x, 402);
        do_hit(7'd10, 1'b0);
        check("hit1_hp", boss_hp, 90);
        check("hit1_inv", boss_invuln, 1);
        tick(5);
        do_hit(7'd5, 1'b0);
        check("hit_ignored_hp", boss_hp, 90);
        tick(24);
        check("inv_last_frame", boss_invuln, 1);
        tick(1);
        check("inv_expired", boss_invuln, 0);
        do_hit(7'd10, 1'b0);
        check("hit2_hp", boss_hp, 80);

        // 120th patrol tick triggers the jump
        tick(89);
        check("pre_jump_x", boss_x, 640);
        check("pre_jump_y", boss_y, 505);
        tick(1);
        check("jump_t1_y", boss_y, 493);
        tick(11);
        check("jump_peak_y", boss_y, 427);
        check("jump_peak_x", boss_x, 664);

        // Pause mid-jump: everything holds, hits ignored
        game_active = 2'd2;
        tick(50);
        do_hit(7'd10, 1'b0);
        check("pause_y", boss_y, 427);
        check("pause_x", boss_x, 664);
        check("pause_hp", boss_hp, 80);
        check("pause_inv", boss_invuln, 0);
        game_active = 2'd1;
        tick(1);
        check("resume_apex_y", boss_y, 427);
        tick(1);
        check("resume_y", boss_y, 428);
        check("resume_x", boss_x, 668);
        tick(11);
        check("land_y", boss_y, 505);
        check("land_x", boss_x, 690);

        // Right edge clamp and turn-around
        tick(2);
        check("edge_clamp_x", boss_x, 694);
        tick(1);
        check("edge_turn_x", boss_x, 692);

        // Saturating kill with simultaneous frame tick
        do_hit(7'd73, 1'b0);
        check("hp_7", boss_hp, 7);
        tick(30);
        check("left_x", boss_x, 632);
        check("inv_clear2", boss_invuln, 0);
        do_hit(7'd0, 1'b0);
        check("zero_dmg_hp", boss_hp, 7);
        check("zero_dmg_inv", boss_invuln, 1);
        tick(30);
        check("pre_kill_x", boss_x, 572);
        do_hit(7'd20, 1'b1);
        check("kill_hp", boss_hp, 0);
        check("kill_def", boss_defeated, 1);
        check("kill_x", boss_x, 570);
        @(negedge clk);
        check("def_pulse_end", boss_defeated, 0);
        tick(3);
        do_hit(7'd5, 1'b0);
        check("dead_x", boss_x, 570);
        check("dead_y", boss_y, 505);
        check("dead_hp", boss_hp, 0);
        check("dead_def", boss_defeated, 0);

        // Menu returns everything to reset values
        game_active = 2'd0;
        @(negedge clk);
        check("menu_x", boss_x, 400);
        check("menu_y", boss_y, 95);
        check("menu_hp", boss_hp, 100);
        check("menu_inv", boss_invuln, 0);
        game_active = 2'd1;
        tick(2);
        check("respawn_y", boss_y, 97);

        $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
        $finish;
    end

endmodule
`default_nettype wire
